// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Accepts one M-extension op in IDLE, iterates BITS_PER_CYCLE bits per cycle in CALC,
// then presents a one-cycle result pulse in DONE.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request, accepted only in IDLE when kill is low
//   kill    abort the op in flight (flush/trap)
//   funct3  M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a    rs1 data (multiplicand / dividend)
//   op_b    rs2 data (multiplier / divisor)
//   rd_in   destination register index
//   busy    high while in CALC or DONE
//   done    one-cycle result-valid pulse
//   wr_en   register-file write enable, equal to done
//   rd_out  destination index, valid while done
//   result  result data, valid while done

module muldiv_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            wr_en,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    localparam int unsigned N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     addend_q, addend_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4:0]          rd_out_q, rd_out_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept
    logic            is_div, signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div   = funct3[2];
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = signed_a && op_a[XLEN-1];
        sign_b   = signed_b && op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;

        div_by_zero = (op_b == '0);
        div_ovf     = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU
        if (div_by_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : op_a;
        end
    end

    // One CALC step: BITS_PER_CYCLE radix-2 iterations chained combinationally.
    // acc holds {hi, lo}: for multiply {partial product, remaining multiplier},
    // for divide {partial remainder, dividend shifting into quotient}.
    logic [2*XLEN:0]   m_tmp;
    logic [XLEN:0]     r_tmp;
    logic [XLEN-1:0]   q_tmp;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        m_tmp = {1'b0, acc_q};
        r_tmp = {1'b0, acc_q[2*XLEN-1:XLEN]};
        q_tmp = acc_q[XLEN-1:0];
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (m_tmp[0]) begin
                m_tmp[2*XLEN:XLEN] = m_tmp[2*XLEN:XLEN] + {1'b0, addend_q};
            end
            m_tmp = m_tmp >> 1;

            r_tmp = {r_tmp[XLEN-1:0], q_tmp[XLEN-1]};
            q_tmp = {q_tmp[XLEN-2:0], 1'b0};
            if (r_tmp >= {1'b0, addend_q}) begin
                r_tmp    = r_tmp - {1'b0, addend_q};
                q_tmp[0] = 1'b1;
            end
        end
        if (funct3_q[2]) begin
            acc_step = {r_tmp[XLEN-1:0], q_tmp};
        end else begin
            acc_step = m_tmp[2*XLEN-1:0];
        end
    end

    // Sign fix-up and result select on the final step
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_calc;

    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (funct3_q)
            3'b000:                 res_calc = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_calc = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_calc = quo_fix;
            default:                res_calc = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rd_out_d = rd_out_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    funct3_d = funct3;
                    rd_d     = rd_in;
                    cnt_d    = '0;
                    if (is_div) begin
                        acc_d    = {{XLEN{1'b0}}, mag_a};
                        addend_d = mag_b;
                        // Remainder takes the dividend's sign
                        neg_d    = funct3[1] ? sign_a : (sign_a ^ sign_b);
                    end else begin
                        acc_d    = {{XLEN{1'b0}}, mag_b};
                        addend_d = mag_a;
                        neg_d    = sign_a ^ sign_b;
                    end
                    if (is_div && (div_by_zero || div_ovf)) begin
                        state_d  = DONE;
                        result_d = special_res;
                        rd_out_d = rd_in;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = res_calc;
                        rd_out_d = rd_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            addend_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    // A kill arriving in the DONE cycle must stop the falling-edge register-file
    // write, so the registered pulse is gated by kill.
    assign done   = done_q && !kill;
    assign wr_en  = done_q && !kill;
    assign busy   = busy_q;
    assign rd_out = rd_out_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a radix-1 and a radix-4 instance, each with
// its own stimulus signals and expected-result queue.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  start;
    logic [1:0]  kill;
    logic [2:0]  f3  [2];
    logic [31:0] a   [2];
    logic [31:0] b   [2];
    logic [4:0]  rd  [2];
    logic [1:0]  busy, done, wr_en;
    logic [4:0]  rd_out [2];
    logic [31:0] res    [2];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .kill(kill[0]),
        .funct3(f3[0]), .op_a(a[0]), .op_b(b[0]), .rd_in(rd[0]),
        .busy(busy[0]), .done(done[0]), .wr_en(wr_en[0]),
        .rd_out(rd_out[0]), .result(res[0])
    );

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_r4 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .kill(kill[1]),
        .funct3(f3[1]), .op_a(a[1]), .op_b(b[1]), .rd_in(rd[1]),
        .busy(busy[1]), .done(done[1]), .wr_en(wr_en[1]),
        .rd_out(rd_out[1]), .result(res[1])
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec_t;

    exp_t q1[$];
    exp_t q4[$];
    vec_t vecs[16];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [1:0] prev_done = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops and compares on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (done[d]) begin
                have = 1'b0;
                if (d == 0 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end else if (d == 1 && q4.size() > 0) begin
                    e = q4.pop_front();
                    have = 1'b1;
                end
                check($sformatf("u%0d_done_expected", d), 64'(have), 64'd1);
                if (have) begin
                    check($sformatf("u%0d_result", d), 64'(res[d]), 64'(e.res));
                    check($sformatf("u%0d_rd_out", d), 64'(rd_out[d]), 64'(e.rd));
                    check($sformatf("u%0d_latency_cycle", d), 64'(cyc), 64'(e.due));
                    check($sformatf("u%0d_wr_en", d), 64'(wr_en[d]), 64'd1);
                end
                check($sformatf("u%0d_done_width", d), 64'(prev_done[d]), 64'd0);
            end
            prev_done[d] <= done[d];
        end
    end

    task automatic issue(input int d, input logic [2:0] f, input logic [31:0] oa,
                         input logic [31:0] ob, input logic [4:0] r, input bit push,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        @(negedge clk);
        f3[d] = f; a[d] = oa; b[d] = ob; rd[d] = r; start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        // Scramble operands: they must not be sampled after accept
        a[d] = $urandom; b[d] = $urandom; rd[d] = 5'($urandom);
        if (push) begin
            e.res = exp; e.rd = r; e.due = cyc + lat - 1;
            if (d == 0) q1.push_back(e); else q4.push_back(e);
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy[d] && ((d == 0) ? q1.size() : q4.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("u%0d_idle_within_bound", d), 64'(ok), 64'd1);
    endtask

    task automatic check_zero_outputs(input int d, input string tag);
        check({tag, "_busy"},   64'(busy[d]),   64'd0);
        check({tag, "_done"},   64'(done[d]),   64'd0);
        check({tag, "_wr_en"},  64'(wr_en[d]),  64'd0);
        check({tag, "_rd_out"}, 64'(rd_out[d]), 64'd0);
        check({tag, "_result"}, 64'(res[d]),    64'd0);
    endtask

    initial begin
        int cnt;
        bit seen;
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0};
        vecs[7]  = '{3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[8]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[12] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
        vecs[13] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
        vecs[14] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

        rst = 2'b11; start = 2'b00; kill = 2'b00;
        for (int d = 0; d < 2; d++) begin
            f3[d] = '0; a[d] = '0; b[d] = '0; rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;
        @(negedge clk);
        check_zero_outputs(0, "reset_r1");
        check_zero_outputs(1, "reset_r4");

        // MUL with busy-length check
        issue(0, 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd9, 1'b1, 32'hFFFF_FFEB, 33);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy[0]) break;
            cnt++;
        end
        check("mul_busy_cycles", 64'(cnt), 64'd33);

        // Full vector table on the radix-1 unit
        for (int i = 0; i < 16; i++) begin
            issue(0, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, vecs[i].exp,
                  vecs[i].spec ? 1 : 33);
            wait_idle(0);
        end

        // kill in CALC cycle 10
        issue(0, 3'b000, 32'h5, 32'h6, 5'd3, 1'b0, 32'h0, 0);
        repeat (9) @(posedge clk);
        #1;
        kill[0] = 1'b1;
        @(posedge clk);
        #1;
        kill[0] = 1'b0;
        check("kill_busy_low", 64'(busy[0]), 64'd0);
        check("kill_no_done", 64'(done[0]), 64'd0);
        repeat (40) @(negedge clk);

        // start pulses during CALC are ignored
        issue(0, 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd12, 1'b1, 32'hFFFF_FFEB, 33);
        repeat (4) @(posedge clk);
        #1;
        f3[0] = 3'b101; a[0] = 32'd100; b[0] = 32'd7; rd[0] = 5'd20; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_idle(0);
        repeat (40) @(negedge clk);

        // reset in CALC cycle 5
        issue(0, 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 1'b0, 32'h0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check_zero_outputs(0, "midop_reset");
        repeat (40) @(negedge clk);

        // Back-to-back: DIVU issued in the first IDLE cycle after done
        issue(0, 3'b000, 32'h7, 32'hFFFF_FFFD, 5'd4, 1'b1, 32'hFFFF_FFEB, 33);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_first_done_seen", 64'(seen), 64'd1);
        issue(0, 3'b101, 32'hFFFF_FFF9, 32'h2, 5'd5, 1'b1, 32'h7FFF_FFFC, 33);
        wait_idle(0);

        // Radix-4 unit: same vectors, 9-cycle latency
        for (int i = 0; i < 16; i++) begin
            issue(1, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 16), 1'b1, vecs[i].exp,
                  vecs[i].spec ? 1 : 9);
            wait_idle(1);
        end

        repeat (5) @(negedge clk);
        check("r1_queue_drained", 64'(q1.size()), 64'd0);
        check("r4_queue_drained", 64'(q4.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit sitting between the register-file read ports and the writeback path of the core.
- Consumes rs1/rs2 read data plus funct3 and rd, and computes over multiple cycles.
- Presents a one-cycle result pulse (result, rd_out, wr_en) to the register-file write mux.
- Drives busy so the control path stalls fetch/PC while an M-op is in flight.

Parameters:
- XLEN, 32: operand/result width.
- BITS_PER_CYCLE, 1: radix bits retired per CALC cycle; legal values 1, 2, 4. N_ITER = XLEN/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only in IDLE.
- kill  in  1  abort current op (pipeline flush/trap).
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 data (dividend / multiplicand).
- op_b  in  XLEN  rs2 data (divisor / multiplier).
- rd_in  in  5  destination register index.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle result-valid pulse.
- wr_en  out  1  equals done; the register file itself discards writes to x0.
- rd_out  out  5  latched rd_in, valid while done.
- result  out  XLEN  latched result, valid while done.

Behaviour:
- States: IDLE, CALC, DONE. All outputs registered.
- Reset: state=IDLE, busy=0, done=0, wr_en=0, rd_out=0, result=0, counter=0. Reset has priority over everything, including mid-operation; no done is produced for an op in flight.
- Accept: at a rising edge in IDLE with start=1 and kill=0.
  - Latch funct3 and rd_in.
  - Latch the magnitudes of op_a/op_b per signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - All other ops: unsigned.
  - Latch the result sign: product sign = sign_a XOR sign_b; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Go to CALC with counter=0.
- Divide special cases, detected at accept; the unit goes straight to DONE on the next edge with no CALC cycles.
  - op_b==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
- CALC, one iteration step per edge, counter increments:
  - Multiply: unsigned shift-add into a 2*XLEN accumulator.
  - Divide: unsigned restoring divide producing quotient and remainder.
  - When counter==N_ITER-1 at an edge, go to DONE.
  - CALC therefore lasts exactly N_ITER cycles.
- Result select, computed on the CALC->DONE edge after the sign fix-up (two's-complement negate of the 64-bit product, quotient or remainder as applicable):
  - MUL: low XLEN of product.
  - MULH/MULHSU/MULHU: high XLEN of product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: done=wr_en=1 for exactly one cycle with result/rd_out valid; the next edge returns to IDLE. done falls to 0 the next cycle; result/rd_out hold their values until the next DONE.
- Latency: accept edge -> done high N_ITER+1 cycles later (33 for defaults); 1 cycle for special cases.
- busy rises the cycle after the accept edge and falls the cycle after DONE. The control path holds start/operands stable only for the accept cycle.
- start in CALC or DONE is ignored; no queueing. The next op may be accepted in the first IDLE cycle after done.
- kill:
  - In CALC or DONE: go to IDLE on the next edge and force done=wr_en=0 that cycle; a kill in the DONE cycle suppresses the pulse.
  - kill with start in IDLE: no accept.
- Operand inputs are not sampled after accept; changes during CALC have no effect.
- Register file writes on the falling clock edge. done is registered off the rising edge, so the write lands within the done cycle.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, rd_out=rd_in, done exactly 33 cycles after accept, busy high 33 cycles, done width 1.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with done 1 cycle after accept.
- Abort cases:
  - kill in CALC cycle 10: busy low next cycle, no done.
  - start pulses during CALC: ignored; the original result still appears at cycle 33.
  - reset asserted in CALC cycle 5: all outputs 0 next cycle, no done.
- Back-to-back and BITS_PER_CYCLE=4:
  - MUL then DIVU issued in the IDLE cycle right after done: both results correct.
  - With BITS_PER_CYCLE=4, latency is 9 cycles and results are identical to the radix-1 run.
